pc_sequencer: RTL and testbench

//  Next-PC controller for the 16-bit single-cycle core. Drives the target input of the

---
 rtl/pc_sequencer_pkg.sv | 52 +++++
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer_ret_stack.sv | 51 +++++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state encoding and the
// RUN-mode target select codes.
package pc_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HALT = ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        SEL_RESET = 3'd0,
        SEL_HOLD  = 3'd1,
        SEL_RET   = 3'd2,
        SEL_CALL  = 3'd3,
        SEL_JMP   = 3'd4,
        SEL_BR    = 3'd5,
        SEL_STEP  = 3'd6
    } sel_e;

    // RUN-mode priority; a ret on empty or call on full stack falls back to a step.
    function automatic sel_e run_select(
        input logic halt_req,
        input logic stall,
        input logic ret,
        input logic call,
        input logic jmp,
        input logic br_taken,
        input logic stack_empty,
        input logic stack_full
    );
        sel_e sel;
        if (halt_req || stall)
            sel = SEL_HOLD;
        else if (ret)
            sel = stack_empty ? SEL_STEP : SEL_RET;
        else if (call)
            sel = stack_full ? SEL_STEP : SEL_CALL;
        else if (jmp)
            sel = SEL_JMP;
        else if (br_taken)
            sel = SEL_BR;
        else
            sel = SEL_STEP;
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/flag bundle between decoder, PC register and the next-PC sequencer.
interface pc_seq_if #(
    parameter int PC_W = 6
);
    logic            en;
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_off;
    logic            jmp;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] jmp_addr;
    logic            halt_req;
    logic [PC_W-1:0] pc_cur;
    logic [PC_W-1:0] target;
    logic            fetch_valid;
    logic            halted;
    logic            stack_ovf;
    logic            stack_unf;

    modport master (
        output en, stall, br_taken, br_off, jmp, call, ret, jmp_addr, halt_req, pc_cur,
        input  target, fetch_valid, halted, stack_ovf, stack_unf
    );

    modport slave (
        input  en, stall, br_taken, br_off, jmp, call, ret, jmp_addr, halt_req, pc_cur,
        output target, fetch_valid, halted, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Pop wins over push; push on full and pop on empty are ignored.
module ret_stack #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  sp_q;
    logic [AW:0]  sp_d;
    logic [AW:0]  sp_m1;
    logic         do_push;
    logic         do_pop;

    assign sp_m1   = sp_q - 1'b1;
    assign full    = (sp_q == (AW+1)'(DEPTH));
    assign empty   = (sp_q == '0);
    assign top     = mem_q[sp_m1[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;

    always_comb begin
        sp_d = sp_q;
        if (do_pop)
            sp_d = sp_m1;
        else if (do_push)
            sp_d = sp_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            sp_q <= sp_d;
            if (do_push)
                mem_q[sp_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: drives the PC register target each cycle (step, branch, jump,
// call/return via ret_stack, stall, halt).
//   state | meaning
//   IDLE  | waiting for en, target = RESET_VEC
//   RUN   | normal sequencing by priority select
//   HALT  | target frozen at pc_cur until reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W        = 6,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
    input logic     clk,
    input logic     rst,
    pc_seq_if.slave bus
);
    state_e          state_q;
    state_e          state_d;
    logic            fetch_valid_q;
    logic            halted_q;
    logic            ovf_q;
    logic            unf_q;

    sel_e            sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] target;
    logic            push;
    logic            pop;
    logic            st_full;
    logic            st_empty;
    logic [PC_W-1:0] st_top;
    logic            ovf_set;
    logic            unf_set;
    logic            run_active;

    assign pc_inc = bus.pc_cur + PC_W'(1);
    assign pc_br  = bus.pc_cur + bus.br_off;

    ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .full  (st_full),
        .empty (st_empty),
        .top   (st_top)
    );

    always_comb begin
        sel = SEL_RESET;
        case (state_q)
            IDLE:    sel = SEL_RESET;
            RUN:     sel = run_select(bus.halt_req, bus.stall, bus.ret, bus.call,
                                      bus.jmp, bus.br_taken, st_empty, st_full);
            HALT:    sel = SEL_HOLD;
            default: sel = SEL_RESET;
        endcase
    end

    assign run_active = (state_q == RUN) && !bus.halt_req && !bus.stall;
    assign push       = (sel == SEL_CALL);
    assign pop        = (sel == SEL_RET);
    assign unf_set    = run_active && bus.ret && st_empty;
    assign ovf_set    = run_active && !bus.ret && bus.call && st_full;

    always_comb begin
        target = RESET_VEC;
        case (sel)
            SEL_RESET: target = RESET_VEC;
            SEL_HOLD:  target = bus.pc_cur;
            SEL_RET:   target = st_top;
            SEL_CALL:  target = bus.jmp_addr;
            SEL_JMP:   target = bus.jmp_addr;
            SEL_BR:    target = pc_br;
            SEL_STEP:  target = pc_inc;
            default:   target = RESET_VEC;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en) state_d = RUN;
            RUN:     if (bus.halt_req) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= (state_d == RUN) && !bus.stall;
            halted_q      <= (state_d == HALT);
            ovf_q         <= ovf_q | ovf_set;
            unf_q         <= unf_q | unf_set;
        end
    end

    assign bus.target      = target;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;
    localparam int PC_W  = 6;
    localparam int DEPTH = 4;
    localparam int MODV  = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pc_seq_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(
        .PC_W        (PC_W),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (6'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 idle, 1 run, 2 halt
    int         m_state;
    logic [5:0] m_stk[$];
    bit         m_ovf, m_unf, m_fv, m_halted;
    logic [5:0] exp_target;
    int         n_state;
    bit         n_push, n_pop, n_ovf, n_unf, n_fv, n_halted;
    logic [5:0] n_push_val;

    task automatic model_reset();
        m_state = 0;
        m_stk.delete();
        m_ovf = 0; m_unf = 0; m_fv = 0; m_halted = 0;
    endtask

    task automatic model_eval();
        int pc;
        int off;
        pc = int'(bus.pc_cur);
        off = (int'(bus.br_off) >= MODV/2) ? int'(bus.br_off) - MODV : int'(bus.br_off);
        n_push = 0; n_pop = 0; n_ovf = m_ovf; n_unf = m_unf; n_state = m_state;
        n_push_val = 6'((pc + 1) % MODV);
        if (m_state == 0) begin
            exp_target = 6'd0;
            if (bus.en) n_state = 1;
        end else if (m_state == 2) begin
            exp_target = bus.pc_cur;
        end else if (bus.halt_req) begin
            exp_target = bus.pc_cur;
            n_state = 2;
        end else if (bus.stall) begin
            exp_target = bus.pc_cur;
        end else if (bus.ret) begin
            if (m_stk.size() == 0) begin
                n_unf = 1;
                exp_target = 6'((pc + 1) % MODV);
            end else begin
                exp_target = m_stk[$];
                n_pop = 1;
            end
        end else if (bus.call) begin
            if (m_stk.size() == DEPTH) begin
                n_ovf = 1;
                exp_target = 6'((pc + 1) % MODV);
            end else begin
                exp_target = bus.jmp_addr;
                n_push = 1;
            end
        end else if (bus.jmp) begin
            exp_target = bus.jmp_addr;
        end else if (bus.br_taken) begin
            exp_target = 6'((pc + off + MODV) % MODV);
        end else begin
            exp_target = 6'((pc + 1) % MODV);
        end
        n_fv = (n_state == 1) && !bus.stall;
        n_halted = (n_state == 2);
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        #1;
        m_state = n_state;
        if (n_pop) void'(m_stk.pop_back());
        if (n_push) m_stk.push_back(n_push_val);
        m_ovf = n_ovf; m_unf = n_unf; m_fv = n_fv; m_halted = n_halted;
    endtask

    task automatic clear_inputs();
        bus.en = 0; bus.stall = 0; bus.br_taken = 0; bus.br_off = '0;
        bus.jmp = 0; bus.call = 0; bus.ret = 0; bus.jmp_addr = '0;
        bus.halt_req = 0; bus.pc_cur = '0;
    endtask

    task automatic pulse_reset();
        rst = 0;
        #2;
        model_reset();
        rst = 1;
        #1;
    endtask

    task automatic enter_run();
        clear_inputs();
        pulse_reset();
        bus.en = 1;
        cyc();
        bus.en = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        model_reset();
        #12;
        n_checks++;
        if (bus.target !== 6'd0) begin n_fail++; $display("FAIL reset_target: got %0d expected 0", bus.target); end
        n_checks++;
        if ({bus.fetch_valid, bus.halted, bus.stack_ovf, bus.stack_unf} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                {bus.fetch_valid, bus.halted, bus.stack_ovf, bus.stack_unf});
        end
        rst = 1;
        @(posedge clk); #1;
        bus.pc_cur = 6'd17;
        cyc();
        n_checks++;
        if (bus.target !== 6'd0) begin n_fail++; $display("FAIL idle_hold: got %0d expected 0", bus.target); end
        n_checks++;
        if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL idle_fv: got %0d expected 0", bus.fetch_valid); end
    endtask

    task automatic test_sequential();
        clear_inputs();
        pulse_reset();
        bus.en = 1;
        #1;
        model_eval();
        n_checks++;
        if (bus.target !== exp_target) begin n_fail++; $display("FAIL seq_start: got %0d expected %0d", bus.target, exp_target); end
        cyc();
        bus.en = 0;
        n_checks++;
        if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv: got %0d expected 1", bus.fetch_valid); end
        for (int i = 0; i < 64; i++) begin
            bus.pc_cur = exp_target;
            #1;
            model_eval();
            n_checks++;
            if (bus.target !== exp_target) begin n_fail++; $display("FAIL seq_step: got %0d expected %0d", bus.target, exp_target); end
            cyc();
        end
        n_checks++;
        if (exp_target !== 6'd0) begin n_fail++; $display("FAIL seq_wrap: got %0d expected 0", exp_target); end
    endtask

    task automatic test_branch();
        logic [5:0] pcs  [3] = '{6'd10, 6'd62, 6'd0};
        logic [5:0] offs [3] = '{6'h3E, 6'd5, 6'h20};
        logic [5:0] want [3] = '{6'd8, 6'd3, 6'd32};
        enter_run();
        for (int i = 0; i < 3; i++) begin
            bus.br_taken = 1; bus.pc_cur = pcs[i]; bus.br_off = offs[i];
            #1;
            model_eval();
            n_checks++;
            if (bus.target !== want[i] || exp_target !== want[i]) begin
                n_fail++; $display("FAIL branch_%0d: got %0d expected %0d", i, bus.target, want[i]);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_call_ret();
        enter_run();
        bus.call = 1; bus.pc_cur = 6'd5; bus.jmp_addr = 6'd20;
        #1;
        n_checks++;
        if (bus.target !== 6'd20) begin n_fail++; $display("FAIL call_target: got %0d expected 20", bus.target); end
        cyc();
        clear_inputs();
        bus.ret = 1; bus.pc_cur = 6'd25;
        #1;
        n_checks++;
        if (bus.target !== 6'd6) begin n_fail++; $display("FAIL ret_target: got %0d expected 6", bus.target); end
        cyc();
        bus.pc_cur = 6'd30;
        #1;
        model_eval();
        n_checks++;
        if (bus.target !== 6'd31 || exp_target !== 6'd31) begin
            n_fail++; $display("FAIL ret_empty_after: got %0d expected 31", bus.target);
        end
        cyc();
        n_checks++;
        if (bus.stack_unf !== 1'b1) begin n_fail++; $display("FAIL ret_empty_unf: got %0d expected 1", bus.stack_unf); end
        clear_inputs();
    endtask

    task automatic test_stack_limits();
        enter_run();
        for (int i = 0; i < 5; i++) begin
            bus.call = 1; bus.pc_cur = 6'(i * 7 + 1); bus.jmp_addr = 6'($urandom_range(0, 63));
            #1;
            model_eval();
            n_checks++;
            if (bus.target !== exp_target) begin n_fail++; $display("FAIL ovf_call_%0d: got %0d expected %0d", i, bus.target, exp_target); end
            cyc();
        end
        n_checks++;
        if (bus.stack_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0d expected 1", bus.stack_ovf); end
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            bus.ret = 1; bus.pc_cur = 6'(40 + i);
            #1;
            model_eval();
            n_checks++;
            if (bus.target !== exp_target) begin n_fail++; $display("FAIL unf_ret_%0d: got %0d expected %0d", i, bus.target, exp_target); end
            cyc();
        end
        n_checks++;
        if ({bus.stack_ovf, bus.stack_unf} !== 2'b11) begin
            n_fail++; $display("FAIL sticky_flags: got %b expected 11", {bus.stack_ovf, bus.stack_unf});
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        enter_run();
        bus.call = 1; bus.pc_cur = 6'd5; bus.jmp_addr = 6'd20;
        cyc();
        bus.pc_cur = 6'd21; bus.jmp_addr = 6'd40;
        cyc();
        clear_inputs();
        bus.stall = 1; bus.jmp = 1; bus.call = 1; bus.ret = 1; bus.br_taken = 1;
        bus.pc_cur = 6'd41; bus.jmp_addr = 6'd9;
        #1;
        n_checks++;
        if (bus.target !== 6'd41) begin n_fail++; $display("FAIL stall_target: got %0d expected 41", bus.target); end
        cyc();
        n_checks++;
        if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_fv: got %0d expected 0", bus.fetch_valid); end
        clear_inputs();
        bus.call = 1; bus.ret = 1; bus.pc_cur = 6'd41; bus.jmp_addr = 6'd9;
        #1;
        n_checks++;
        if (bus.target !== 6'd22) begin n_fail++; $display("FAIL callret_target: got %0d expected 22", bus.target); end
        cyc();
        clear_inputs();
        bus.ret = 1; bus.pc_cur = 6'd7;
        #1;
        n_checks++;
        if (bus.target !== 6'd6) begin n_fail++; $display("FAIL callret_next: got %0d expected 6", bus.target); end
        cyc();
        bus.pc_cur = 6'd9;
        #1;
        n_checks++;
        if (bus.target !== 6'd10) begin n_fail++; $display("FAIL callret_empty: got %0d expected 10", bus.target); end
        cyc();
        n_checks++;
        if ({bus.stack_ovf, bus.stack_unf} !== 2'b01) begin
            n_fail++; $display("FAIL callret_flags: got %b expected 01", {bus.stack_ovf, bus.stack_unf});
        end
        clear_inputs();
    endtask

    task automatic test_random();
        enter_run();
        for (int i = 0; i < 400; i++) begin
            bus.en       = 1'($urandom_range(0, 1));
            bus.stall    = ($urandom_range(0, 5) == 0);
            bus.ret      = ($urandom_range(0, 3) == 0);
            bus.call     = ($urandom_range(0, 2) == 0);
            bus.jmp      = ($urandom_range(0, 4) == 0);
            bus.br_taken = ($urandom_range(0, 3) == 0);
            bus.br_off   = 6'($urandom_range(0, 63));
            bus.jmp_addr = 6'($urandom_range(0, 63));
            bus.pc_cur   = ($urandom_range(0, 1) == 0) ? exp_target : 6'($urandom_range(0, 63));
            #1;
            model_eval();
            n_checks++;
            if (bus.target !== exp_target) begin n_fail++; $display("FAIL rand_target_%0d: got %0d expected %0d", i, bus.target, exp_target); end
            cyc();
            n_checks++;
            if ({bus.fetch_valid, bus.halted, bus.stack_ovf, bus.stack_unf} !== {m_fv, m_halted, m_ovf, m_unf}) begin
                n_fail++; $display("FAIL rand_flags_%0d: got %b expected %b", i,
                    {bus.fetch_valid, bus.halted, bus.stack_ovf, bus.stack_unf}, {m_fv, m_halted, m_ovf, m_unf});
            end
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        enter_run();
        bus.ret = 1; bus.pc_cur = 6'd3;
        cyc();
        clear_inputs();
        bus.halt_req = 1; bus.pc_cur = 6'd12; bus.jmp = 1; bus.jmp_addr = 6'd50;
        #1;
        n_checks++;
        if (bus.target !== 6'd12) begin n_fail++; $display("FAIL halt_target: got %0d expected 12", bus.target); end
        cyc();
        n_checks++;
        if ({bus.halted, bus.fetch_valid} !== 2'b10) begin
            n_fail++; $display("FAIL halt_state: got %b expected 10", {bus.halted, bus.fetch_valid});
        end
        clear_inputs();
        bus.en = 1; bus.jmp = 1; bus.call = 1; bus.jmp_addr = 6'd33; bus.pc_cur = 6'd12;
        #1;
        n_checks++;
        if (bus.target !== 6'd12) begin n_fail++; $display("FAIL halt_ignore: got %0d expected 12", bus.target); end
        cyc();
        n_checks++;
        if ({bus.halted, bus.stack_ovf, bus.stack_unf} !== 3'b101) begin
            n_fail++; $display("FAIL halt_hold: got %b expected 101", {bus.halted, bus.stack_ovf, bus.stack_unf});
        end
        #2;
        rst = 0;
        #1;
        model_reset();
        n_checks++;
        if (bus.target !== 6'd0) begin n_fail++; $display("FAIL halt_rst_target: got %0d expected 0", bus.target); end
        n_checks++;
        if ({bus.fetch_valid, bus.halted, bus.stack_ovf, bus.stack_unf} !== 4'b0000) begin
            n_fail++; $display("FAIL halt_rst_flags: got %b expected 0000",
                {bus.fetch_valid, bus.halted, bus.stack_ovf, bus.stack_unf});
        end
        #3;
        rst = 1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_stack_limits();
        test_priority();
        test_random();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
